macload_csr_bank: RTL

CSR-side responder for the MAC-load address-update protocol. It holds the activation (A) and weight (W) pointer, stride, rollback and skip registers. It accepts software CSR accesses and autonomous pointer-update writes from the MAC-load controller. It drives the counter-clear strobes back to that controller. It sits in the core's CSR block, between the CSR instruction path and the MAC-load controller.

---
 rtl/macload_csr_bank.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/macload_csr_bank.sv
// MAC-load CSR bank: A/W pointer, stride, rollback, skip registers.
// Ports: clk_i/rst_i (sync, active-high); sw_csr_* software CSR access
// with combinational sw_csr_rdata_o and sw_hit_o; mlc_* controller
// pointer updates with registered mlc_drop_o; register contents out;
// csr_a_rstn_o/csr_w_rstn_o registered active-low counter-clear strobes.
// Option: define MACLOAD_CSR_PERF_EN for a_upd_cnt/w_upd_cnt at BASE+8/9.

package macload_csr_pkg;
    localparam logic [1:0] CSR_OP_NONE  = 2'd0;
    localparam logic [1:0] CSR_OP_WRITE = 2'd1;
    localparam logic [1:0] CSR_OP_SET   = 2'd2;
    localparam logic [1:0] CSR_OP_CLEAR = 2'd3;
    localparam logic [11:0] CSR_BASE   = 12'h7D0;
    localparam logic [11:0] CSR_A_ADDR = CSR_BASE;
    localparam logic [11:0] CSR_W_ADDR = CSR_BASE + 12'd1;
endpackage

module macload_csr_bank
    import macload_csr_pkg::*;
#(
    parameter logic [11:0] BASE = 12'h7D0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  sw_csr_op_i,
    input  logic [11:0] sw_csr_addr_i,
    input  logic [31:0] sw_csr_wdata_i,
    output logic [31:0] sw_csr_rdata_o,
    output logic        sw_hit_o,
    input  logic [1:0]  mlc_csr_op_i,
    input  logic [11:0] mlc_csr_addr_i,
    input  logic [31:0] mlc_wdata_i,
    output logic        mlc_drop_o,
    output logic [31:0] a_address_o,
    output logic [31:0] w_address_o,
    output logic [31:0] a_stride_o,
    output logic [31:0] w_stride_o,
    output logic [31:0] a_rollback_o,
    output logic [31:0] w_rollback_o,
    output logic [31:0] a_skip_o,
    output logic [31:0] w_skip_o,
    output logic        csr_a_rstn_o,
    output logic        csr_w_rstn_o
);

`ifdef MACLOAD_CSR_PERF_EN
    localparam logic [11:0] NMAP = 12'd10;
`else
    localparam logic [11:0] NMAP = 12'd8;
`endif

    logic [31:0] regs_q [8];
    logic [11:0] sw_off;
    logic [11:0] mlc_off;
    logic [2:0]  sw_idx;
    logic [2:0]  mlc_idx;
    logic        sw_reg_hit;
    logic        sw_act;
    logic        mlc_wr;
    logic        mlc_ok;
    logic        mlc_commit;
    logic [31:0] sw_new;
    logic        drop_q;
    logic        a_rstn_q;
    logic        w_rstn_q;

    // Offsets wrap mod 4096, so addresses below BASE never hit.
    assign sw_off     = sw_csr_addr_i - BASE;
    assign mlc_off    = mlc_csr_addr_i - BASE;
    assign sw_idx     = sw_off[2:0];
    assign mlc_idx    = {2'b00, mlc_off[0]};
    assign sw_reg_hit = sw_off < 12'd8;
    assign sw_hit_o   = sw_off < NMAP;
    assign sw_act     = sw_reg_hit && (sw_csr_op_i != CSR_OP_NONE);

    assign mlc_wr = mlc_csr_op_i == CSR_OP_WRITE;
    assign mlc_ok = mlc_wr && (mlc_off < 12'd2);
    // Software wins a same-register collision; controller data is lost.
    assign mlc_commit = mlc_ok && !(sw_act && (sw_idx == mlc_idx));

    always_comb begin
        sw_new = regs_q[sw_idx];
        unique case (sw_csr_op_i)
            CSR_OP_WRITE: sw_new = sw_csr_wdata_i;
            CSR_OP_SET:   sw_new = regs_q[sw_idx] | sw_csr_wdata_i;
            CSR_OP_CLEAR: sw_new = regs_q[sw_idx] & ~sw_csr_wdata_i;
            default:      sw_new = regs_q[sw_idx];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (mlc_commit) begin
                regs_q[mlc_idx] <= mlc_wdata_i;
            end
            if (sw_act) begin
                regs_q[sw_idx] <= sw_new;
            end
        end
    end

    // Even offsets form the A group, odd offsets the W group.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_q   <= 1'b0;
            a_rstn_q <= 1'b0;
            w_rstn_q <= 1'b0;
        end else begin
            drop_q   <= mlc_wr && !mlc_commit;
            a_rstn_q <= !(sw_act && !sw_idx[0]);
            w_rstn_q <= !(sw_act && sw_idx[0]);
        end
    end

`ifdef MACLOAD_CSR_PERF_EN
    logic [31:0] a_cnt_q;
    logic [31:0] w_cnt_q;
    logic        a_clr;
    logic        w_clr;

    assign a_clr = (sw_csr_op_i == CSR_OP_WRITE) && (sw_off == 12'd8);
    assign w_clr = (sw_csr_op_i == CSR_OP_WRITE) && (sw_off == 12'd9);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_cnt_q <= '0;
            w_cnt_q <= '0;
        end else begin
            if (a_clr) begin
                a_cnt_q <= '0;
            end else if (mlc_commit && !mlc_idx[0]) begin
                a_cnt_q <= a_cnt_q + 32'd1;
            end
            if (w_clr) begin
                w_cnt_q <= '0;
            end else if (mlc_commit && mlc_idx[0]) begin
                w_cnt_q <= w_cnt_q + 32'd1;
            end
        end
    end
`endif

    always_comb begin
        sw_csr_rdata_o = '0;
        unique case (1'b1)
            sw_reg_hit:          sw_csr_rdata_o = regs_q[sw_idx];
`ifdef MACLOAD_CSR_PERF_EN
            (sw_off == 12'd8):   sw_csr_rdata_o = a_cnt_q;
            (sw_off == 12'd9):   sw_csr_rdata_o = w_cnt_q;
`endif
            default:             sw_csr_rdata_o = '0;
        endcase
    end

    assign mlc_drop_o   = drop_q;
    assign csr_a_rstn_o = a_rstn_q;
    assign csr_w_rstn_o = w_rstn_q;

    assign a_address_o  = regs_q[0];
    assign w_address_o  = regs_q[1];
    assign a_stride_o   = regs_q[2];
    assign w_stride_o   = regs_q[3];
    assign a_rollback_o = regs_q[4];
    assign w_rollback_o = regs_q[5];
    assign a_skip_o     = regs_q[6];
    assign w_skip_o     = regs_q[7];

endmodule
